// File: rtl/fl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fl_pkg : shared scan-state enum, counter-width helper and GSR constants   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package fl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } scan_state_e;

  localparam string GSR_ENABLED  = "ENABLED";
  localparam string GSR_DISABLED = "DISABLED";

  // Width needed to hold the values 0..n inclusive, never less than one bit.
  function automatic int fl_cnt_width(input int n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fl_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fl_scan_ctrl : IDLE/SHIFT/DONE scan sequencer with an N-cycle shift count |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fl_scan_ctrl
  import fl_pkg::*;
#(
  parameter int N = 16
) (
  input  logic ck_i,
  input  logic rst_i,
  input  logic start_i,
  output logic shift_o,
  output logic busy_o,
  output logic done_o,
  output logic load_valid_o
);

  localparam int            CW     = fl_cnt_width(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  scan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge ck_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_o      = 1'b0;
    done_o       = 1'b0;
    load_valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        shift_o = 1'b1;
        // The edge that performs the Nth shift also hands over to DONE.
        if (cnt_q == LAST_C) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        done_o       = 1'b1;
        load_valid_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/fl_scan_reg_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fl_scan_reg_chain : WIDTH x DEPTH mux-input register pipeline; optional   |
// | serial scan of the whole chain when FL_SCAN_CHAIN_EN is defined.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fl_scan_reg_chain
  import fl_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '1,
  parameter string            GSR   = "ENABLED"
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             CE,
  input  logic             SD,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID
`ifdef FL_SCAN_CHAIN_EN
  , input  logic           SCAN_START
  , input  logic           SCAN_SI
  , output logic           SCAN_SO
  , output logic           SCAN_BUSY
  , output logic           SCAN_DONE
`endif
);

  localparam int            N          = WIDTH * DEPTH;
  localparam int            FW         = fl_cnt_width(DEPTH);
  localparam logic [FW-1:0] FULL_C     = FW'(DEPTH);
  localparam bit            GSR_EN     = (GSR == GSR_ENABLED);
  localparam logic [N-1:0]  INIT_CHAIN = {DEPTH{INIT}};

  // Flat chain: stage s occupies bits [s*WIDTH +: WIDTH], so the scan shift
  // and the word-wise pipeline advance are both plain left shifts.
  logic [N-1:0]     chain_q, chain_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] w_sel;
  logic             w_advance;
  logic             w_shift;
  logic             w_load_valid;
  logic             w_si;

`ifdef FL_SCAN_CHAIN_EN
  logic w_busy;

  fl_scan_ctrl #(
    .N (N)
  ) u_scan_ctrl (
    .ck_i         (CK),
    .rst_i        (RST),
    .start_i      (SCAN_START),
    .shift_o      (w_shift),
    .busy_o       (w_busy),
    .done_o       (SCAN_DONE),
    .load_valid_o (w_load_valid)
  );

  assign SCAN_BUSY = w_busy;
  assign SCAN_SO   = chain_q[N-1];
  assign w_advance = CE & ~w_busy;
  assign w_si      = SCAN_SI;
`else
  assign w_advance    = CE;
  assign w_shift      = 1'b0;
  assign w_load_valid = 1'b0;
  assign w_si         = 1'b0;
`endif

  assign w_sel = SD ? D1 : D0;

  always_comb begin
    chain_d = chain_q;
    fill_d  = fill_q;
    if (w_shift) begin
      chain_d = (chain_q << 1) | N'(w_si);
    end else if (w_advance) begin
      chain_d = (chain_q << WIDTH) | N'(w_sel);
    end
    if (w_load_valid) begin
      fill_d = FULL_C;
    end else if (w_advance && (fill_q != FULL_C)) begin
      fill_d = fill_q + FW'(1);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      fill_q <= '0;
      if (GSR_EN) begin
        chain_q <= INIT_CHAIN;
      end
    end else begin
      chain_q <= chain_d;
      fill_q  <= fill_d;
    end
  end

  assign Q       = chain_q[N-1 -: WIDTH];
  assign Q_VALID = (fill_q == FULL_C);

endmodule
`default_nettype wire

// File: tb/tb_fl_scan_reg_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fl_scan_reg_chain : scoreboard bench, GSR enabled and disabled copies  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_fl_scan_reg_chain;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W * D;

  logic         ck;
  logic         rst, rst2, ce, sd, start, si;
  logic [W-1:0] d0, d1;
  logic [W-1:0] q, q2;
  logic         qv, qv2;
`ifdef FL_SCAN_CHAIN_EN
  logic so, busy, done, so2, busy2, done2;
`endif

  fl_scan_reg_chain #(
    .WIDTH (W), .DEPTH (D), .INIT (8'hFF), .GSR ("ENABLED")
  ) dut (
    .CK (ck), .RST (rst), .CE (ce), .SD (sd), .D0 (d0), .D1 (d1),
    .Q (q), .Q_VALID (qv)
`ifdef FL_SCAN_CHAIN_EN
    , .SCAN_START (start), .SCAN_SI (si), .SCAN_SO (so)
    , .SCAN_BUSY (busy), .SCAN_DONE (done)
`endif
  );

  fl_scan_reg_chain #(
    .WIDTH (W), .DEPTH (D), .INIT (8'hFF), .GSR ("DISABLED")
  ) dut2 (
    .CK (ck), .RST (rst2), .CE (ce), .SD (sd), .D0 (d0), .D1 (d1),
    .Q (q2), .Q_VALID (qv2)
`ifdef FL_SCAN_CHAIN_EN
    , .SCAN_START (1'b0), .SCAN_SI (1'b0), .SCAN_SO (so2)
    , .SCAN_BUSY (busy2), .SCAN_DONE (done2)
`endif
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic [W-1:0] q;
    logic         v;
    logic         busy;
    logic         done;
    logic         so;
    logic [W-1:0] q2;
    logic         v2;
    bit           chk2;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: stage words (index 0 = input stage), fill count, and the
  // number of scan edges still to come (N shifts plus the DONE edge).
  logic [W-1:0] m_st [D];
  int           m_fill = 0;
  int           m_left = 0;
  logic [W-1:0] m2_st [D];
  int           m2_fill = 0;
  int           m2_loads = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic s,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic st, input logic sin, input logic r2);
    logic [N-1:0] ch;
    exp_t         e;
    @(negedge ck);
    rst = r; ce = c; sd = s; d0 = a; d1 = b; start = st; si = sin; rst2 = r2;
    if (r) begin
      for (int i = 0; i < D; i++) m_st[i] = 8'hFF;
      m_fill = 0;
      m_left = 0;
    end else if (m_left > 1) begin
      for (int i = 0; i < D; i++) ch[i*W +: W] = m_st[i];
      ch = {ch[N-2:0], sin};
      for (int i = 0; i < D; i++) m_st[i] = ch[i*W +: W];
      m_left--;
    end else if (m_left == 1) begin
      m_fill = D;
      m_left = 0;
    end else begin
      if (c) begin
        for (int i = D - 1; i > 0; i--) m_st[i] = m_st[i-1];
        m_st[0] = s ? b : a;
        if (m_fill < D) m_fill++;
      end
`ifdef FL_SCAN_CHAIN_EN
      if (st) m_left = N + 1;
`endif
    end
    if (r2) begin
      m2_fill = 0;
    end else if (c) begin
      for (int i = D - 1; i > 0; i--) m2_st[i] = m2_st[i-1];
      m2_st[0] = s ? b : a;
      if (m2_fill < D) m2_fill++;
      m2_loads++;
    end
    e.q    = m_st[D-1];
    e.v    = (m_fill == D);
    e.busy = (m_left > 0);
    e.done = (m_left == 1);
    e.so   = m_st[D-1][W-1];
    e.q2   = m2_st[D-1];
    e.v2   = (m2_fill == D);
    e.chk2 = (m2_loads >= D);
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge ck);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("Q", q, e.q);
        chk("Q_VALID", {7'd0, qv}, {7'd0, e.v});
        chk("Q_VALID_gsr_off", {7'd0, qv2}, {7'd0, e.v2});
        if (e.chk2) chk("Q_gsr_off", q2, e.q2);
`ifdef FL_SCAN_CHAIN_EN
        chk("SCAN_BUSY", {7'd0, busy}, {7'd0, e.busy});
        chk("SCAN_DONE", {7'd0, done}, {7'd0, e.done});
        chk("SCAN_SO", {7'd0, so}, {7'd0, e.so});
        chk("SCAN_BUSY_gsr_off", {7'd0, busy2}, 8'd0);
`endif
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] pat;
    rst = 1'b1; rst2 = 1'b1; ce = 1'b0; sd = 1'b0; start = 1'b0; si = 1'b0;
    d0 = '0; d1 = '0;
    for (int i = 0; i < D; i++) begin
      m_st[i]  = 8'hFF;
      m2_st[i] = '0;
    end

    // Reset both copies.
    repeat (2) step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1);

    // GSR disabled: load 5A twice, then reset must keep the data.
    repeat (2) step(1, 1, 0, 8'h5A, 8'h00, 0, 0, 0);
    step(1, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    // Mux select.
    step(0, 1, 0, 8'h12, 8'h34, 0, 0, 0);
    step(0, 1, 1, 8'h12, 8'h34, 0, 0, 0);
    step(0, 1, 0, 8'h56, 8'h78, 0, 0, 0);

    // CE hold with changing data.
    step(0, 1, 0, 8'hA5, 8'h00, 0, 0, 0);
    step(0, 1, 0, 8'h3C, 8'h00, 0, 0, 0);
    repeat (5) step(0, 0, 1'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0);

`ifdef FL_SCAN_CHAIN_EN
    // Full scan of BEEF with pipeline inputs toggling underneath.
    pat = 16'hBEEF;
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    for (int i = 0; i < N; i++)
      step(0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 0, pat[N-1-i], 0);
    step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    step(0, 1, 0, 8'h11, 8'h22, 0, 0, 0);

    // Abort after the fifth shift; a start mid-shift must be ignored.
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 8'($urandom), 8'h00, (i == 2) ? 1'b1 : 1'b0, 1'($urandom), 0);
    step(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
`else
    pat = 16'h0000;
    step(0, 1, 0, 8'h77, 8'h00, 0, pat[0], 0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           8'($urandom), 8'($urandom), ($urandom_range(0, 14) == 0), 1'($urandom),
           ($urandom_range(0, 29) == 0));

    step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    repeat (3) @(posedge ck);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
